mgpio_wb_master: RTL



---
 rtl/mgpio_wb_master.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mgpio_wb_master.sv
// Single-outstanding Wishbone classic initiator for the GPIO register space.
// Converts valid/ready register requests into bus cycles with retry, error and timeout handling.
module mgpio_wb_master #(
    parameter int ADDR_WIDTH  = 13,
    parameter int MAX_RETRIES = 3,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [7:0]            req_data,
    input  logic                  req_write,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [7:0]            rsp_data,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [7:0]            dat_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic                  sel_o,
    input  logic [7:0]            dat_i,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic                  rty_i
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(MAX_RETRIES);

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_ERR     = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;
    localparam logic [1:0] ST_RETRY   = 2'b11;

    typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   adr_reg, adr_next;
    logic [7:0]              dat_reg, dat_next;
    logic                    we_reg, we_next;
    logic [RW-1:0]           retry_cnt_reg, retry_cnt_next;
    logic [TW-1:0]           timer_reg, timer_next;
    logic [7:0]              rsp_data_reg, rsp_data_next;
    logic [1:0]              rsp_status_reg, rsp_status_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            adr_reg        <= '0;
            dat_reg        <= '0;
            we_reg         <= 1'b0;
            retry_cnt_reg  <= '0;
            timer_reg      <= '0;
            rsp_data_reg   <= '0;
            rsp_status_reg <= ST_OK;
        end else begin
            state_reg      <= state_next;
            adr_reg        <= adr_next;
            dat_reg        <= dat_next;
            we_reg         <= we_next;
            retry_cnt_reg  <= retry_cnt_next;
            timer_reg      <= timer_next;
            rsp_data_reg   <= rsp_data_next;
            rsp_status_reg <= rsp_status_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        adr_next        = adr_reg;
        dat_next        = dat_reg;
        we_next         = we_reg;
        retry_cnt_next  = retry_cnt_reg;
        timer_next      = timer_reg;
        rsp_data_next   = rsp_data_reg;
        rsp_status_next = rsp_status_reg;

        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    adr_next       = req_addr;
                    dat_next       = req_data;
                    we_next        = req_write;
                    retry_cnt_next = '0;
                    timer_next     = '0;
                    state_next     = BUS;
                end
            end
            BUS: begin
                // Termination priority: err > ack > rty; any of them beats the timeout.
                if (err_i) begin
                    rsp_status_next = ST_ERR;
                    rsp_data_next   = 8'h00;
                    state_next      = RESP;
                end else if (ack_i) begin
                    rsp_status_next = ST_OK;
                    rsp_data_next   = we_reg ? 8'h00 : dat_i;
                    state_next      = RESP;
                end else if (rty_i) begin
                    if (retry_cnt_reg == RETRY_LAST) begin
                        rsp_status_next = ST_RETRY;
                        rsp_data_next   = 8'h00;
                        state_next      = RESP;
                    end else begin
                        retry_cnt_next = retry_cnt_reg + RW'(1);
                        state_next     = BACKOFF;
                    end
                end else if (timer_reg == TIMER_LAST) begin
                    rsp_status_next = ST_TIMEOUT;
                    rsp_data_next   = 8'h00;
                    state_next      = RESP;
                end else begin
                    timer_next = timer_reg + TW'(1);
                end
            end
            BACKOFF: begin
                timer_next = '0;
                state_next = BUS;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign req_ready  = rst_n && (state_reg == IDLE);
    assign rsp_valid  = (state_reg == RESP);
    assign rsp_data   = rsp_data_reg;
    assign rsp_status = rsp_status_reg;
    assign cyc_o      = (state_reg == BUS);
    assign stb_o      = (state_reg == BUS);
    assign sel_o      = (state_reg == BUS);
    assign adr_o      = adr_reg;
    assign dat_o      = dat_reg;
    assign we_o       = we_reg;

endmodule
